// File: rtl/uart_tx_bridge_pkg.sv
// Shared types and register-map constants for the UART transmit bridge.
package uart_tx_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_ACTIVE    = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers, read data = head entry (no latency).
// Push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the natural pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// Memory-mapped bridge from core stores to a UART transmitter: FIFO + start/handshake FSM.
// Push-to-uart_start is two edges; a full FIFO drops the byte and sets sticky overflow.
module uart_tx_bridge
  import uart_tx_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic [7:0]  uart_data,
  output logic        uart_start,
  input  logic        uart_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t       state;
  tx_state_t       state_next;
  logic            pop;
  logic            push_req;
  logic            status_wr;
  logic            overflow;
  logic            overflow_evt;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      fifo_head;

  assign push_req  = write_enable && (address == BASE_ADDR + TXDATA_OFS) && write_mask[0];
  assign status_wr = write_enable && (address == BASE_ADDR + STATUS_OFS) && write_mask[0];
  // A pop on the same edge frees the slot, so only a pop-less push to a full FIFO is lost.
  assign overflow_evt = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (uart_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      uart_start <= 1'b0;
      uart_data  <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      uart_start <= (state_next == START);
      if (pop) uart_data <= fifo_head;
      if (overflow_evt)                   overflow <= 1'b1;
      else if (status_wr && write_data[ST_OVERFLOW]) overflow <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    if (address == BASE_ADDR + STATUS_OFS) begin
      read_data[ST_FULL]     = fifo_full;
      read_data[ST_EMPTY]    = fifo_empty;
      read_data[ST_ACTIVE]   = (state != IDLE);
      read_data[ST_OVERFLOW] = overflow;
      read_data[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end
  end

endmodule
